// File: rtl/cmd_pkg.sv
// Shared types and widths for the UART command assembler.
package cmd_pkg;

  typedef enum logic {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } asm_state_t;

  localparam int CMD_W  = 16;
  localparam int BYTE_W = 8;

endpackage

// File: rtl/uart_cmd_assembler.sv
// Pairs two consecutive UART bytes (high then low) into a 16-bit command,
// with an inter-byte timeout for resync and a sticky overrun flag.
module uart_cmd_assembler
  import cmd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              clr_rx_rdy,
  output logic [CMD_W-1:0]  cmd,
  output logic              cmd_rdy,
  input  logic              clr_cmd_rdy,
  output logic              frame_err,
  output logic              overrun
);

  localparam int              TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);

  asm_state_t        r_state;
  logic [BYTE_W-1:0] r_hi;
  logic [CMD_W-1:0]  r_cmd;
  logic              r_cmd_rdy;
  logic              r_overrun;
  logic              r_frame_err;
  logic [TO_W-1:0]   r_cnt;
  logic              r_skip;
  logic              w_accept;

  // The receiver still shows rdy for one cycle after we clear it; r_skip masks that echo.
  assign w_accept   = rx_rdy & ~r_skip;
  assign clr_rx_rdy = w_accept;

  assign cmd       = r_cmd;
  assign cmd_rdy   = r_cmd_rdy;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

  // Byte-pairing FSM with inline timeout counter and command/handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= WAIT_HI;
      r_hi        <= {BYTE_W{1'b0}};
      r_cmd       <= {CMD_W{1'b0}};
      r_cmd_rdy   <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_cnt       <= {TO_W{1'b0}};
      r_skip      <= 1'b0;
    end else begin
      r_skip      <= w_accept;
      r_frame_err <= 1'b0;

      if (clr_cmd_rdy) begin
        r_cmd_rdy <= 1'b0;
        r_overrun <= 1'b0;
      end

      case (r_state)
        WAIT_HI: begin
          if (w_accept) begin
            r_hi    <= rx_data;
            r_cnt   <= {TO_W{1'b0}};
            r_state <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          // A byte in the cycle the counter hits the limit still completes the command.
          if (w_accept) begin
            r_cmd     <= {r_hi, rx_data};
            r_cmd_rdy <= 1'b1;
            if (r_cmd_rdy && !clr_cmd_rdy) begin
              r_overrun <= 1'b1;
            end
            r_state   <= WAIT_HI;
          end else if (r_cnt == TO_MAX) begin
            r_frame_err <= 1'b1;
            r_hi        <= {BYTE_W{1'b0}};
            r_cnt       <= {TO_W{1'b0}};
            r_state     <= WAIT_HI;
          end else begin
            r_cnt <= r_cnt + TO_W'(1);
          end
        end
        default: begin
          r_state <= WAIT_HI;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Self-checking bench for uart_cmd_assembler: directed scenarios plus a
// randomized byte/ack stream checked against a gap-based behavioural model.
module tb_uart_cmd_assembler;

  localparam int TO = 3000;

  logic        clk;
  logic        rst_n;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        frame_err;
  logic        overrun;

  int n_tests;
  int n_fail;

  // receiver model: rdy stays up one extra cycle after a byte is presented
  bit   hold;
  logic last_clr;
  int   n_clr_pulses;
  int   n_ferr;

  // behavioural model, expressed as gaps between accepted bytes
  logic [15:0] m_cmd;
  bit          m_rdy;
  bit          m_ov;
  bit          m_fe;
  bit          m_pend;
  logic [7:0]  m_hi;
  int          m_age;

  uart_cmd_assembler #(.TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .clr_rx_rdy (clr_rx_rdy),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_cmd  = 16'h0000;
    m_rdy  = 1'b0;
    m_ov   = 1'b0;
    m_fe   = 1'b0;
    m_pend = 1'b0;
    m_hi   = 8'h00;
    m_age  = 0;
  endtask

  // One cycle: a presented byte is accepted; the first byte of a pair opens a
  // window of TO+1 further cycles for the second one.
  task automatic model_advance(input bit present, input logic [7:0] data, input bit clr);
    bit nr;
    bit no;
    nr   = m_rdy;
    no   = m_ov;
    m_fe = 1'b0;
    if (clr) begin
      nr = 1'b0;
      no = 1'b0;
    end
    if (m_pend) m_age++;
    if (present) begin
      if (m_pend) begin
        m_cmd  = {m_hi, data};
        if (m_rdy && !clr) no = 1'b1;
        nr     = 1'b1;
        m_pend = 1'b0;
      end else begin
        m_pend = 1'b1;
        m_hi   = data;
        m_age  = 0;
      end
    end else if (m_pend && m_age == TO + 1) begin
      m_fe   = 1'b1;
      m_pend = 1'b0;
    end
    m_rdy = nr;
    m_ov  = no;
  endtask

  task automatic step(input bit present, input logic [7:0] data, input bit clr);
    @(negedge clk);
    rx_rdy      = present | hold;
    if (present) rx_data = data;
    clr_cmd_rdy = clr;
    #1;
    last_clr = clr_rx_rdy;
    if (clr_rx_rdy) n_clr_pulses++;
    model_advance(present, data, clr);
    @(posedge clk);
    #1;
    if (frame_err) n_ferr++;
    hold = present;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0);
    step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00; clr_cmd_rdy = 1'b0; hold = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (cmd !== 16'h0000 || cmd_rdy !== 1'b0 || overrun !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got cmd=%h rdy=%b ov=%b fe=%b, want 0000 0 0 0", cmd, cmd_rdy, overrun, frame_err);
    end
    n_tests++;
    if (clr_rx_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_clr_rx: got %b want 0", clr_rx_rdy);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    n_clr_pulses = 0;
    step(1'b1, 8'hA5, 1'b0);
    idle(2000);
    step(1'b1, 8'h3C, 1'b0);
    n_tests++;
    if (cmd !== 16'hA53C || cmd_rdy !== 1'b1 || last_clr !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_cmd: got cmd=%h rdy=%b clr=%b, want a53c 1 1", cmd, cmd_rdy, last_clr);
    end
    idle(4);
    n_tests++;
    if (n_clr_pulses != 2) begin
      n_fail++;
      $display("FAIL basic_clr_pulses: got %0d want 2", n_clr_pulses);
    end
  endtask

  task automatic test_timeout();
    int first_fe;
    first_fe = -1;
    n_ferr   = 0;
    step(1'b1, 8'h12, 1'b0);
    for (int i = 1; i <= TO + 5; i++) begin
      step(1'b0, 8'h00, 1'b0);
      if (frame_err && first_fe < 0) first_fe = i;
    end
    n_tests++;
    if (n_ferr != 1 || first_fe != TO + 1) begin
      n_fail++;
      $display("FAIL timeout_pulse: got count=%0d at=%0d, want 1 at %0d", n_ferr, first_fe, TO + 1);
    end
    n_tests++;
    if (cmd !== 16'hA53C || cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_cmd_hold: got %h/%b want a53c/1", cmd, cmd_rdy);
    end
    step(1'b0, 8'h00, 1'b1);
    send(8'h34);
    step(1'b1, 8'h56, 1'b0);
    n_tests++;
    if (cmd !== 16'h3456 || cmd_rdy !== 1'b1 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_resync: got cmd=%h rdy=%b ov=%b, want 3456 1 0", cmd, cmd_rdy, overrun);
    end
    idle(1);
  endtask

  task automatic test_overrun();
    step(1'b0, 8'h00, 1'b1);
    send(8'h11); send(8'h11);
    send(8'h22); step(1'b1, 8'h22, 1'b0);
    n_tests++;
    if (cmd !== 16'h2222 || overrun !== 1'b1 || cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: got cmd=%h ov=%b rdy=%b, want 2222 1 1", cmd, overrun, cmd_rdy);
    end
    step(1'b0, 8'h00, 1'b1);
    n_tests++;
    if (cmd_rdy !== 1'b0 || overrun !== 1'b0 || cmd !== 16'h2222) begin
      n_fail++;
      $display("FAIL overrun_clear: got rdy=%b ov=%b cmd=%h, want 0 0 2222", cmd_rdy, overrun, cmd);
    end
  endtask

  task automatic test_simultaneous();
    send(8'hCA); send(8'hFE);
    send(8'hBE);
    step(1'b1, 8'hEF, 1'b1);
    n_tests++;
    if (cmd !== 16'hBEEF || cmd_rdy !== 1'b1 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_clr: got cmd=%h rdy=%b ov=%b, want beef 1 0", cmd, cmd_rdy, overrun);
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    n_clr_pulses = 0;
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    n_tests++;
    if (cmd !== 16'h00FF || cmd_rdy !== 1'b1 || n_clr_pulses != 2) begin
      n_fail++;
      $display("FAIL b2b_hold: got cmd=%h rdy=%b pulses=%0d, want 00ff 1 2", cmd, cmd_rdy, n_clr_pulses);
    end
  endtask

  task automatic test_boundary();
    n_ferr = 0;
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h9A, 1'b0);
    idle(TO);
    step(1'b1, 8'h55, 1'b0);
    idle(2);
    n_tests++;
    if (cmd !== 16'h9A55 || cmd_rdy !== 1'b1 || n_ferr != 0) begin
      n_fail++;
      $display("FAIL boundary_accept: got cmd=%h rdy=%b ferr=%0d, want 9a55 1 0", cmd, cmd_rdy, n_ferr);
    end
  endtask

  task automatic test_reset_mid();
    send(8'h77);
    idle(3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (cmd !== 16'h0000 || cmd_rdy !== 1'b0 || overrun !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got cmd=%h rdy=%b ov=%b fe=%b, want 0000 0 0 0", cmd, cmd_rdy, overrun, frame_err);
    end
    model_reset();
    hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h01);
    step(1'b1, 8'h02, 1'b0);
    n_tests++;
    if (cmd !== 16'h0102 || cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_resume: got cmd=%h rdy=%b, want 0102 1", cmd, cmd_rdy);
    end
    idle(1);
  endtask

  task automatic test_random();
    int gap;
    bit clr;
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 39) == 0) gap = $urandom_range(TO - 2, TO + 2);
      else gap = $urandom_range(0, 12);
      for (int g = 0; g < gap + 1; g++) begin
        clr = ($urandom_range(0, 7) == 0);
        step(1'b0, 8'h00, clr);
        n_tests++;
        if (cmd !== m_cmd || cmd_rdy !== m_rdy || overrun !== m_ov || frame_err !== m_fe || last_clr !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_idle it=%0d: got cmd=%h rdy=%b ov=%b fe=%b clr=%b, want %h %b %b %b 0",
                   it, cmd, cmd_rdy, overrun, frame_err, last_clr, m_cmd, m_rdy, m_ov, m_fe);
        end
      end
      clr = ($urandom_range(0, 3) == 0);
      step(1'b1, 8'($urandom_range(0, 255)), clr);
      n_tests++;
      if (cmd !== m_cmd || cmd_rdy !== m_rdy || overrun !== m_ov || frame_err !== m_fe || last_clr !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_byte it=%0d: got cmd=%h rdy=%b ov=%b fe=%b clr=%b, want %h %b %b %b 1",
                 it, cmd, cmd_rdy, overrun, frame_err, last_clr, m_cmd, m_rdy, m_ov, m_fe);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    n_clr_pulses = 0;
    n_ferr  = 0;
    last_clr = 1'b0;
    test_reset();
    test_basic();
    test_timeout();
    test_overrun();
    test_simultaneous();
    test_back_to_back();
    test_boundary();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
